// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register pending (busy) scoreboard.
// Reads are combinational. BYPASS selects whether a read also sees a write in the same cycle.

module regfile_mp_sb_rd #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]         addr,
    input  logic [NREGS*XLEN-1:0] regs_flat,
    input  logic [NREGS-1:0]      busy,
    input  logic [NREGS-1:0]      wr_en,
    input  logic [NREGS*XLEN-1:0] wr_data_flat,
    output logic [XLEN-1:0]       data,
    output logic                  rbusy
);
    logic byp;

    // Out-of-range addresses match no register, so they read 0 and are never busy.
    always_comb begin
        data  = '0;
        rbusy = 1'b0;
        byp   = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (addr == AW'(r)) begin
                byp   = (BYPASS != 0) && wr_en[r];
                data  = byp ? wr_data_flat[r*XLEN +: XLEN] : regs_flat[r*XLEN +: XLEN];
                rbusy = busy[r] & ~byp;
            end
        end
    end
endmodule

module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                clk_regfile,
    input  logic                reset_regfile,
    input  logic [NWR-1:0]      we_i,
    input  logic [NWR*AW-1:0]   waddr_i,
    input  logic [NWR*XLEN-1:0] wdata_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    output logic [NRD-1:0]      rbusy_o,
    input  logic                issue_valid_i,
    input  logic [AW-1:0]       issue_rd_i,
    output logic                issue_ready_o,
    output logic [NREGS-1:0]    busy_o,
    output logic [AW:0]         pending_cnt_o
);
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0][XLEN-1:0] wr_data;
    logic [NREGS-1:0]           wr_en;
    logic [NREGS-1:0]           busy, busy_nxt, issue_sel, issue_set;
    logic [AW:0]                pending_cnt, cnt_nxt;

    // Per-register write decode; later ports override earlier ones.
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int k = 0; k < NWR; k++) begin
                if (!reset_regfile && we_i[k] && (ZERO_REG == 0 || r != 0) &&
                    waddr_i[k*AW +: AW] == AW'(r)) begin
                    wr_en[r]   = 1'b1;
                    wr_data[r] = wdata_i[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Readiness looks only at the stored busy bit: a same-cycle writeback gives no credit.
    always_comb begin
        issue_sel = '0;
        for (int r = 0; r < NREGS; r++)
            issue_sel[r] = (issue_rd_i == AW'(r));
        issue_ready_o = ~reset_regfile & ~|(busy & issue_sel);
        issue_set     = '0;
        for (int r = 0; r < NREGS; r++)
            issue_set[r] = issue_sel[r] & issue_valid_i & issue_ready_o &
                           ((ZERO_REG == 0) || (r != 0));
        // Set after clear: a new owner wins over the retiring writeback.
        busy_nxt = (busy & ~wr_en) | issue_set;
        cnt_nxt  = '0;
        for (int r = 0; r < NREGS; r++)
            cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
    end

    always_ff @(posedge clk_regfile) begin
        if (reset_regfile) begin
            regs        <= '0;
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                if (wr_en[r]) regs[r] <= wr_data[r];
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_mp_sb_rd #(
            .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(BYPASS)
        ) u_rd (
            .addr        (raddr_i[p*AW +: AW]),
            .regs_flat   (regs),
            .busy        (busy),
            .wr_en       (wr_en),
            .wr_data_flat(wr_data),
            .data        (rdata_o[p*XLEN +: XLEN]),
            .rbusy       (rbusy_o[p])
        );
    end

    assign busy_o        = busy;
    assign pending_cnt_o = pending_cnt;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench: one bypassing and one non-bypassing instance share stimulus and a single
// array-based reference model; a negedge monitor compares both against queued expectations.

module tb_regfile_mp_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 24;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD*AW-1:0]   raddr;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;

    logic [NRD*XLEN-1:0] rdata_b, rdata_n;
    logic [NRD-1:0]      rbusy_b, rbusy_n;
    logic                ready_b, ready_n;
    logic [NREGS-1:0]    busy_b, busy_n;
    logic [AW:0]         cnt_b, cnt_n;

    always #5 clk = ~clk;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk_regfile(clk), .reset_regfile(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b), .issue_valid_i(issue_valid),
        .issue_rd_i(issue_rd), .issue_ready_o(ready_b), .busy_o(busy_b), .pending_cnt_o(cnt_b));

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk_regfile(clk), .reset_regfile(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata_n), .rbusy_o(rbusy_n), .issue_valid_i(issue_valid),
        .issue_rd_i(issue_rd), .issue_ready_o(ready_n), .busy_o(busy_n), .pending_cnt_o(cnt_n));

    typedef struct {
        logic [NRD*XLEN-1:0] rd_b, rd_n;
        logic [NRD-1:0]      rb_b, rb_n;
        logic                ready;
        logic [NREGS-1:0]    busy;
        logic [AW:0]         cnt;
        string               tag;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_regs[NREGS];
    bit          m_busy[NREGS];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic bit ok(int a);
        return (a > 0) && (a < NREGS);
    endfunction

    task automatic chk(input string nm, input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%s: got %h expected %h", nm, tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rdata_byp",  e.tag, 64'(rdata_b), 64'(e.rd_b));
            chk("rdata_nobyp", e.tag, 64'(rdata_n), 64'(e.rd_n));
            chk("rbusy_byp",  e.tag, 64'(rbusy_b), 64'(e.rb_b));
            chk("rbusy_nobyp", e.tag, 64'(rbusy_n), 64'(e.rb_n));
            chk("ready_byp",  e.tag, 64'(ready_b), 64'(e.ready));
            chk("ready_nobyp", e.tag, 64'(ready_n), 64'(e.ready));
            chk("busy_byp",   e.tag, 64'(busy_b),  64'(e.busy));
            chk("busy_nobyp", e.tag, 64'(busy_n),  64'(e.busy));
            chk("cnt_byp",    e.tag, 64'(cnt_b),   64'(e.cnt));
            chk("cnt_nobyp",  e.tag, 64'(cnt_n),   64'(e.cnt));
        end
    end

    task automatic clr();
        we = '0; waddr = '0; wdata = '0; raddr = '0; issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic set_w(input int k, input bit en, input int a, input logic [31:0] d);
        we[k] = en;
        waddr[k*AW +: AW] = a[AW-1:0];
        wdata[k*XLEN +: XLEN] = d;
    endtask

    task automatic set_r(input int p, input int a);
        raddr[p*AW +: AW] = a[AW-1:0];
    endtask

    task automatic set_iss(input bit v, input int rd);
        issue_valid = v;
        issue_rd = rd[AW-1:0];
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Expected outputs for the cycle now on the inputs, then advance the model across the edge.
    task automatic cycle(input string tag);
        exp_t        e;
        bit          hit[32];
        logic [31:0] hv[32];
        int          a, rd, c;
        bit          fire;
        for (int i = 0; i < 32; i++) begin hit[i] = 1'b0; hv[i] = '0; end
        for (int k = 0; k < NWR; k++) begin
            a = int'(waddr[k*AW +: AW]);
            if (we[k] && !rst && ok(a)) begin hit[a] = 1'b1; hv[a] = wdata[k*XLEN +: XLEN]; end
        end
        e.rd_b = '0; e.rd_n = '0; e.rb_b = '0; e.rb_n = '0;
        for (int p = 0; p < NRD; p++) begin
            a = int'(raddr[p*AW +: AW]);
            if (ok(a)) begin
                e.rd_b[p*XLEN +: XLEN] = hit[a] ? hv[a] : m_regs[a];
                e.rd_n[p*XLEN +: XLEN] = m_regs[a];
                e.rb_b[p] = m_busy[a] && !hit[a];
                e.rb_n[p] = m_busy[a];
            end
        end
        rd = int'(issue_rd);
        e.ready = !rst && !(ok(rd) && m_busy[rd]);
        c = 0;
        for (int r = 0; r < NREGS; r++) begin
            e.busy[r] = m_busy[r];
            c += int'(m_busy[r]);
        end
        e.cnt = c[AW:0];
        e.tag = tag;
        q.push_back(e);
        fire = issue_valid && e.ready && ok(rd);
        if (rst) model_reset();
        else begin
            for (int r = 0; r < NREGS; r++)
                if (hit[r]) begin m_regs[r] = hv[r]; m_busy[r] = 1'b0; end
            if (fire) m_busy[rd] = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        @(posedge clk); #1;
        model_reset();
        cycle("rst0");
        rst = 1'b0;

        // preload, mark three registers pending, then a single-cycle reset pulse
        for (int i = 1; i <= 4; i++) begin clr(); set_w(0, 1, i, 32'h100 + i); set_r(0, i); cycle("preload"); end
        clr(); set_iss(1, 2);  cycle("pre_iss2");
        clr(); set_iss(1, 10); cycle("pre_iss10");
        clr(); set_iss(1, 11); cycle("pre_iss11");
        clr(); rst = 1'b1; set_iss(1, 12); set_r(0, 2); cycle("rst_pulse");
        rst = 1'b0;
        clr(); set_r(0, 1); set_r(1, 2); cycle("post_rst");

        clr(); set_w(0, 1, 5, 32'hAAAA); set_w(1, 1, 5, 32'hBBBB); set_r(0, 5); cycle("wprio");
        clr(); set_r(0, 5); cycle("wprio_next");

        clr(); set_w(1, 1, 0, 32'hDEAD); set_r(0, 0); set_iss(1, 0); cycle("zero");
        clr(); set_r(0, 0); cycle("zero_next");

        clr(); set_iss(1, 7); set_r(0, 7); cycle("iss7");
        clr(); set_iss(1, 7); set_r(0, 7); cycle("reiss7");
        clr(); set_w(0, 1, 7, 32'h1234); set_r(0, 7); set_r(1, 7); cycle("wb7");
        clr(); set_r(0, 7); cycle("wb7_next");

        clr(); set_iss(1, 9); cycle("iss9");
        clr(); set_w(0, 1, 9, 32'h99); set_iss(1, 9); set_r(0, 9); cycle("clash_busy");
        clr(); set_r(0, 9); cycle("clash_busy_next");
        clr(); set_w(1, 1, 9, 32'h9A); set_iss(1, 9); cycle("clash_free");
        clr(); set_r(0, 9); cycle("clash_free_next");

        clr(); set_w(0, 1, 3, 32'h55); set_r(0, 3); set_r(1, 30); cycle("w3");
        clr(); set_r(0, 3); set_r(1, 24); cycle("w3_next");
        clr(); set_w(0, 1, 26, 32'hF00D); set_iss(1, 27); set_r(0, 26); cycle("oor");

        for (int n = 0; n < 400; n++) begin
            clr();
            rst = ($urandom_range(0, 59) == 0);
            for (int k = 0; k < NWR; k++)
                set_w(k, $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom);
            for (int p = 0; p < NRD; p++)
                if ($urandom_range(0, 1) == 1) raddr[p*AW +: AW] = waddr[$urandom_range(0, NWR-1)*AW +: AW];
                else set_r(p, $urandom_range(0, 31));
            set_iss($urandom_range(0, 2) != 0, $urandom_range(0, 31));
            cycle("rand");
            rst = 1'b0;
        end

        clr();
        for (int n = 0; n < 10 && q.size() != 0; n++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
